// File: rtl/iterative_alu.sv
// Clocked EX-stage integer ALU: registered single-cycle ops plus an iterative
// shift-add multiplier and restoring divider sharing one small FSM.
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    input  logic [4:0]         operation,
    input  logic [WIDTH-1:0]   Op1,
    input  logic [WIDTH-1:0]   Op2,
    input  logic [SHW-1:0]     shamt,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] EXE_Result,
    output logic               EXE_Zero,
    output logic               Overflow,
    output logic               DivByZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_SHLH = 5'h01;
    localparam logic [4:0] OP_OR   = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_AND  = 5'h04;
    localparam logic [4:0] OP_SUB  = 5'h05;
    localparam logic [4:0] OP_SLL  = 5'h06;
    localparam logic [4:0] OP_SRL  = 5'h07;
    localparam logic [4:0] OP_SLT  = 5'h08;
    localparam logic [4:0] OP_SLTU = 5'h09;
    localparam logic [4:0] OP_NOR  = 5'h0A;
    localparam logic [4:0] OP_PSB  = 5'h0B;
    localparam logic [4:0] OP_SRA  = 5'h0E;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_DIV  = 5'h10;
    localparam logic [4:0] OP_PSA  = 5'h16;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, next_state;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     dvsr;
    logic                 neg_q;
    logic                 neg_r;

    logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
    logic [2*WIDTH-1:0]   sc_result;
    logic                 sc_zero, sc_ovf, sc_dbz;
    logic                 go_mul, go_div;
    logic                 accept, last_iter;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_trial;
    logic [WIDTH-1:0]     q_fix, r_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign a_s    = $signed(Op1);
    assign b_s    = $signed(Op2);
    assign sum_s  = a_s + b_s;
    assign diff_s = b_s - a_s;

    assign accept    = (state == IDLE) && start && !flush;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = (state != IDLE);

    // Issue stage: decode and evaluate everything that completes in one cycle
    always_comb begin
        sc_result = '0;
        sc_zero   = 1'b0;
        sc_ovf    = 1'b0;
        sc_dbz    = 1'b0;
        go_mul    = 1'b0;
        go_div    = 1'b0;
        case (operation)
            OP_SHLH: sc_result[WIDTH-1:0] = Op2 << (WIDTH / 2);
            OP_OR:   sc_result[WIDTH-1:0] = Op1 | Op2;
            OP_ADD: begin
                sc_result[WIDTH-1:0] = sum_s;
                sc_ovf = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            OP_AND:  sc_result[WIDTH-1:0] = Op1 & Op2;
            OP_SUB: begin
                sc_result[WIDTH-1:0] = diff_s;
                sc_ovf  = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (diff_s[WIDTH-1] != b_s[WIDTH-1]);
                sc_zero = (diff_s == '0);
            end
            OP_SLL:  sc_result[WIDTH-1:0] = Op2 << shamt;
            OP_SRL:  sc_result[WIDTH-1:0] = Op2 >> shamt;
            OP_SLT:  sc_result[0] = (a_s < b_s);
            OP_SLTU: sc_result[0] = (Op1 < Op2);
            OP_NOR:  sc_result[WIDTH-1:0] = ~(Op1 | Op2);
            OP_PSB:  sc_result[WIDTH-1:0] = Op2;
            OP_SRA:  sc_result[WIDTH-1:0] = b_s >>> shamt;
            OP_PSA:  sc_result[WIDTH-1:0] = Op1;
            OP_MUL:  go_mul = 1'b1;
            OP_DIV: begin
                // Degenerate divides resolve immediately instead of iterating
                if (Op2 == '0) begin
                    sc_result = {Op1, {WIDTH{1'b1}}};
                    sc_dbz    = 1'b1;
                end else if (Op1 == MOST_NEG && Op2 == '1) begin
                    sc_result[WIDTH-1:0] = MOST_NEG;
                    sc_ovf    = 1'b1;
                end else begin
                    go_div = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Iteration stage: one multiplier bit / one quotient bit per cycle
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
    assign mul_next  = {mul_sum, prod[WIDTH-1:1]};
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, dvsr};
    assign q_fix     = cond_neg(quo, neg_q);
    assign r_fix     = cond_neg(rem, neg_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && go_mul)      next_state = MUL;
                else if (accept && go_div) next_state = DIV;
            end
            MUL: if (flush || last_iter) next_state = IDLE;
            DIV: begin
                if (flush)          next_state = IDLE;
                else if (last_iter) next_state = FIX;
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            prod  <= '0;
            mcand <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        mcand <= Op1;
                        prod  <= {{WIDTH{1'b0}}, Op2};
                        rem   <= '0;
                        quo   <= mag(Op1);
                        dvsr  <= mag(Op2);
                        neg_q <= Op1[WIDTH-1] ^ Op2[WIDTH-1];
                        neg_r <= Op1[WIDTH-1];
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + 1'b1;
                end
                DIV: begin
                    rem <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~div_trial[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result stage: outputs change only on the done cycle and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            EXE_Result <= '0;
            EXE_Zero   <= 1'b0;
            Overflow   <= 1'b0;
            DivByZero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && !go_mul && !go_div) begin
                done       <= 1'b1;
                EXE_Result <= sc_result;
                EXE_Zero   <= sc_zero;
                Overflow   <= sc_ovf;
                DivByZero  <= sc_dbz;
            end else if (state == MUL && !flush && last_iter) begin
                done       <= 1'b1;
                EXE_Result <= mul_next;
                EXE_Zero   <= (mul_next == '0);
                Overflow   <= 1'b0;
                DivByZero  <= 1'b0;
            end else if (state == FIX && !flush) begin
                done       <= 1'b1;
                EXE_Result <= {r_fix, q_fix};
                EXE_Zero   <= (quo == '0) && (rem == '0);
                Overflow   <= 1'b0;
                DivByZero  <= 1'b0;
            end
        end
    end

endmodule
